// File: rtl/fifo_pop_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pop_stage_if
// Purpose  : FIFO read port plus downstream valid/ready stream for the drain stage.
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_pop_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_pop;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;

  // The drain stage is the stream source, so it takes the master view.
  modport master (
    input  fifo_empty, fifo_data, out_ready,
    output fifo_pop, out_valid, out_data
  );

  modport slave (
    output fifo_empty, fifo_data, out_ready,
    input  fifo_pop, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/fifo_pop_stage.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pop_stage
// Purpose  : Receive-domain FIFO drain with a 2-entry skid buffer and transfer count.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_pop_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  wire logic                 clk,
  input  wire logic                 nrst,
  input  wire logic                 flush,
  fifo_pop_stage_if.master          bus,
  output logic [1:0]                occupancy,
  output logic [CNT_WIDTH-1:0]      xfer_cnt
);

  typedef enum logic [1:0] {
    c_empty = 2'd0,
    c_one   = 2'd1,
    c_two   = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic                  r_out_valid;
  logic [CNT_WIDTH-1:0]  r_xfer_cnt;

  logic                  w_push;
  logic                  w_drain;

  // Pop depends only on registered state and FIFO/flush, never on out_ready.
  assign w_push  = nrst & ~bus.fifo_empty & ~flush & (r_state != c_two);
  assign w_drain = r_out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= c_empty;
      r_head      <= '0;
      r_tail      <= '0;
      r_out_valid <= 1'b0;
      r_xfer_cnt  <= '0;
    end else begin
      // The downstream saw the handshake, so it counts even during a flush.
      if (w_drain) begin
        r_xfer_cnt <= r_xfer_cnt + c_cnt_one;
      end

      if (flush) begin
        r_state     <= c_empty;
        r_out_valid <= 1'b0;
      end else begin
        case (r_state)
          c_empty: begin
            if (w_push) begin
              r_state     <= c_one;
              r_head      <= bus.fifo_data;
              r_out_valid <= 1'b1;
            end
          end
          c_one: begin
            case ({w_push, w_drain})
              2'b11: r_head <= bus.fifo_data;
              2'b10: begin
                r_state <= c_two;
                r_tail  <= bus.fifo_data;
              end
              2'b01: begin
                r_state     <= c_empty;
                r_out_valid <= 1'b0;
              end
              default: ;
            endcase
          end
          c_two: begin
            if (w_drain) begin
              r_state <= c_one;
              r_head  <= r_tail;
            end
          end
          default: begin
            r_state     <= c_empty;
            r_out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.fifo_pop  = w_push;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_head;
  assign occupancy     = r_state;
  assign xfer_cnt      = r_xfer_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fifo_pop_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_pop_stage
// Purpose  : Directed bench for fifo_pop_stage with a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_pop_stage;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nrst      = 1'b0;
  logic flush     = 1'b0;
  logic out_ready = 1'b0;

  // Simple FIFO source: words are written by the stimulus, consumed on fifo_pop.
  logic [DW-1:0] mem [0:255];
  logic [7:0]    wr_ptr = 8'd0;
  logic [7:0]    rd_ptr = 8'd0;
  wire           fifo_empty = (wr_ptr == rd_ptr);
  wire  [DW-1:0] fifo_data  = mem[rd_ptr];

  fifo_pop_stage_if #(.DATA_WIDTH(DW)) bus16 ();
  fifo_pop_stage_if #(.DATA_WIDTH(DW)) bus4 ();

  assign bus16.fifo_empty = fifo_empty;
  assign bus16.fifo_data  = fifo_data;
  assign bus16.out_ready  = out_ready;
  assign bus4.fifo_empty  = fifo_empty;
  assign bus4.fifo_data   = fifo_data;
  assign bus4.out_ready   = out_ready;

  logic [1:0]  occ16, occ4;
  logic [15:0] cnt16;
  logic [3:0]  cnt4;

  fifo_pop_stage #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut16 (
    .clk(clk), .nrst(nrst), .flush(flush), .bus(bus16.master),
    .occupancy(occ16), .xfer_cnt(cnt16)
  );

  fifo_pop_stage #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .nrst(nrst), .flush(flush), .bus(bus4.master),
    .occupancy(occ4), .xfer_cnt(cnt4)
  );

  always @(posedge clk) begin
    if (bus16.fifo_pop) rd_ptr <= rd_ptr + 8'd1;
  end

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: buffered words in order, total drains, and event logs.
  logic [DW-1:0] mq [$];
  logic [DW-1:0] log_q [$];
  int            pop_cyc [$];
  int            drain_cyc [$];
  int unsigned   mcnt = 0;
  int            mcyc = 0;

  always @(posedge clk or negedge nrst) begin
    logic drn, psh;
    if (!nrst) begin
      mq.delete();
      mcnt = 0;
    end else begin
      mcyc++;
      drn = (mq.size() > 0) && out_ready;
      psh = !fifo_empty && !flush && (mq.size() < 2);
      if (drn) begin
        mcnt++;
        log_q.push_back(mq[0]);
        drain_cyc.push_back(mcyc);
      end
      if (flush) begin
        mq.delete();
      end else begin
        if (drn) void'(mq.pop_front());
        if (psh) begin
          mq.push_back(fifo_data);
          pop_cyc.push_back(mcyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic exp_pop;
    exp_pop = nrst && !fifo_empty && !flush && (mq.size() < 2);
    check("fifo_pop",    32'(bus16.fifo_pop),  32'(exp_pop));
    check("fifo_pop4",   32'(bus4.fifo_pop),   32'(exp_pop));
    check("out_valid",   32'(bus16.out_valid), 32'(mq.size() > 0));
    check("out_valid4",  32'(bus4.out_valid),  32'(mq.size() > 0));
    check("occupancy",   32'(occ16),           32'(mq.size()));
    check("occupancy4",  32'(occ4),            32'(mq.size()));
    check("xfer_cnt",    32'(cnt16),           32'(mcnt[15:0]));
    check("xfer_cnt4",   32'(cnt4),            32'(mcnt[3:0]));
    if (mq.size() > 0) begin
      check("out_data",  bus16.out_data, mq[0]);
      check("out_data4", bus4.out_data,  mq[0]);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [DW-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr      = wr_ptr + 8'd1;
  endtask

  function automatic logic [DW-1:0] log_at(input int i);
    if (i < log_q.size()) return log_q[i];
    return 'x;
  endfunction

  function automatic int q_at(input int q [$], input int i);
    if (i < q.size()) return q[i];
    return -1000;
  endfunction

  initial begin
    logic [15:0] cnt_before;
    bit seen15, seen16, seen17;

    // Reset state
    tick(2);
    check("rst_valid", 32'(bus16.out_valid), 32'd0);
    check("rst_occ",   32'(occ16),           32'd0);
    check("rst_cnt",   32'(cnt16),           32'd0);
    check("rst_data",  bus16.out_data,       32'd0);
    nrst = 1'b1;
    tick(1);

    // Streaming 0x11..0x18
    log_q.delete(); pop_cyc.delete(); drain_cyc.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) load(32'h11 + 32'(i));
    tick(12);
    for (int i = 0; i < 8; i++) check("stream_word", log_at(i), 32'h11 + 32'(i));
    check("stream_pops",     32'(pop_cyc.size()), 32'd8);
    check("stream_pop_span", 32'(q_at(pop_cyc, 7) - q_at(pop_cyc, 0)), 32'd7);
    check("stream_latency",  32'(q_at(drain_cyc, 0) - q_at(pop_cyc, 0)), 32'd1);
    check("stream_drn_span", 32'(q_at(drain_cyc, 7) - q_at(drain_cyc, 0)), 32'd7);
    check("stream_cnt",      32'(cnt16), 32'd8);
    check("stream_occ",      32'(occ16), 32'd0);

    // Backpressure 0xA0..0xA3
    log_q.delete(); pop_cyc.delete(); drain_cyc.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) load(32'hA0 + 32'(i));
    tick(5);
    check("bp_pops", 32'(pop_cyc.size()), 32'd2);
    check("bp_occ",  32'(occ16),          32'd2);
    check("bp_data", bus16.out_data,      32'hA0);
    out_ready = 1'b1;
    tick(6);
    for (int i = 0; i < 4; i++) check("bp_word", log_at(i), 32'hA0 + 32'(i));
    check("bp_drn_span", 32'(q_at(drain_cyc, 3) - q_at(drain_cyc, 0)), 32'd3);

    // Flush from TWO with backpressure
    out_ready = 1'b0;
    load(32'hB0); load(32'hB1); load(32'hB2);
    tick(3);
    check("fl_occ_two", 32'(occ16), 32'd2);
    flush = 1'b1;
    #1;
    check("fl_pop", 32'(bus16.fifo_pop), 32'd0);
    tick(1);
    flush = 1'b0;
    check("fl_occ",   32'(occ16),           32'd0);
    check("fl_valid", 32'(bus16.out_valid), 32'd0);
    log_q.delete();
    tick(1);
    out_ready = 1'b1;
    tick(3);
    check("fl_resume", log_at(0), 32'hB2);

    // Flush in ONE with a simultaneous drain; FIFO still holds a word
    out_ready = 1'b0;
    load(32'hC0); load(32'hC1);
    tick(1);
    check("fd_occ_one", 32'(occ16), 32'd1);
    cnt_before = cnt16;
    flush     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("fd_pop", 32'(bus16.fifo_pop), 32'd0);
    tick(1);
    flush     = 1'b0;
    out_ready = 1'b0;
    check("fd_cnt", 32'(cnt16), 32'(cnt_before + 16'd1));
    check("fd_occ", 32'(occ16), 32'd0);
    log_q.delete();
    tick(1);
    out_ready = 1'b1;
    tick(2);
    check("fd_resume", log_at(0), 32'hC1);

    // Asynchronous reset with two words buffered
    out_ready = 1'b0;
    load(32'hD0); load(32'hD1); load(32'hD2);
    tick(3);
    check("rs_occ_two", 32'(occ16), 32'd2);
    nrst = 1'b0;
    #1;
    check("rs_valid", 32'(bus16.out_valid), 32'd0);
    check("rs_occ",   32'(occ16),           32'd0);
    check("rs_cnt",   32'(cnt16),           32'd0);
    check("rs_cnt4",  32'(cnt4),            32'd0);
    check("rs_pop",   32'(bus16.fifo_pop),  32'd0);
    check("rs_data",  bus16.out_data,       32'd0);
    tick(1);
    nrst = 1'b1;
    log_q.delete();
    out_ready = 1'b1;
    tick(3);
    check("rs_first", log_at(0), 32'hD2);
    check("rs_cnt1",  32'(cnt4),  32'd1);

    // Counter wrap on the 4-bit instance: 17 transfers since reset
    for (int i = 0; i < 16; i++) load(32'hE0 + 32'(i));
    seen15 = 1'b0; seen16 = 1'b0; seen17 = 1'b0;
    for (int i = 0; i < 40 && !seen17; i++) begin
      tick(1);
      if (log_q.size() == 15 && !seen15) begin
        check("wrap_15", 32'(cnt4), 32'd15);
        seen15 = 1'b1;
      end
      if (log_q.size() == 16 && !seen16) begin
        check("wrap_16", 32'(cnt4), 32'd0);
        seen16 = 1'b1;
      end
      if (log_q.size() == 17 && !seen17) begin
        check("wrap_17", 32'(cnt4), 32'd1);
        seen17 = 1'b1;
      end
    end
    check("wrap_reached", 32'({seen15, seen16, seen17}), 32'b111);
    check("wrap_cnt16",   32'(cnt16), 32'd17);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
